// File: rtl/mips_rf_pkg.sv
// Shared register-file constants and the round-robin pointer helper.
// Pure declarations: no state, no latency, no flow control.
package mips_rf_pkg;

   localparam int          REG_AW   = 5;
   localparam int          REG_DW   = 32;
   localparam int          NUM_REGS = 32;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   // A negative grant_idx means no grant this cycle, so the pointer is kept.
   function automatic int rr_next(input int ptr, input int grant_idx, input int n);
      if (grant_idx < 0) begin
         return ptr;
      end
      return (grant_idx + 1) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Purely combinational; a requester with no grant simply waits.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_vld
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port among writeback sources and tracks pending writes.
// Latency: grant -> registered RFWr/A3/WD next edge; ungranted requesters hold until ready.
module rf_wb_arbiter
   import mips_rf_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   input  logic               iss_valid,
   input  logic [AW-1:0]      iss_addr,
   output logic               iss_ok,
   input  logic [AW-1:0]      rs_addr,
   input  logic [AW-1:0]      rt_addr,
   output logic               rs_busy,
   output logic               rt_busy,
   output logic               RFWr,
   output logic [AW-1:0]      A3,
   output logic [DW-1:0]      WD
);

   localparam int PW = $clog2(N_REQ);
   localparam int NR = 1 << AW;

   logic [PW-1:0]   ptr;
   logic [N_REQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_vld;
   logic [AW-1:0]   gnt_addr;
   logic [DW-1:0]   gnt_data;
   logic [NR-1:1]   busy_q;
   logic [NR-1:0]   busy;
   logic            claim;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      gnt_addr  = req_addr[int'(gnt_idx)*AW +: AW];
      gnt_data  = req_data[int'(gnt_idx)*DW +: DW];
      req_ready = rst ? gnt : '0;
   end

   // Register 0 never reads busy, so it has no storage bit.
   assign busy    = {busy_q, 1'b0};
   assign iss_ok  = (iss_addr == '0) | ~busy[iss_addr];
   assign claim   = iss_valid & iss_ok & (iss_addr != '0);
   assign rs_busy = busy[rs_addr];
   assign rt_busy = busy[rt_addr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RFWr <= 1'b0;
         A3   <= '0;
         WD   <= '0;
         ptr  <= '0;
      end else begin
         RFWr <= gnt_vld && (gnt_addr != '0);
         if (gnt_vld) begin
            A3 <= gnt_addr;
            WD <= gnt_data;
         end
         ptr <= PW'(rr_next(int'(ptr), gnt_vld ? int'(gnt_idx) : -1, N_REQ));
      end
   end

   // A new claim outranks the commit that clears the same register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         for (int r = 1; r < NR; r++) begin
            if (claim && (iss_addr == AW'(r))) begin
               busy_q[r] <= 1'b1;
            end else if (RFWr && (A3 == AW'(r))) begin
               busy_q[r] <= 1'b0;
            end
         end
      end
   end

endmodule
